// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the MMIO responder: register offsets inside the
// 16-byte window, bus operation decode and timer control bit positions.
package mmio_responder_pkg;

   localparam int MMIO_WINDOW_BITS = 4;

   // Timer control register bit positions
   localparam int TCTRL_RUN   = 0;
   localparam int TCTRL_CLEAR = 1;

   typedef enum logic [MMIO_WINDOW_BITS-1:0] {
      REG_LED_LO     = 4'h0,
      REG_LED_HI     = 4'h1,
      REG_SW_LO      = 4'h2,
      REG_SW_HI      = 4'h3,
      REG_BTN_STATE  = 4'h4,
      REG_BTN_EDGE   = 4'h5,
      REG_TIMER_LO   = 4'h6,
      REG_TIMER_HI   = 4'h7,
      REG_TIMER_CTRL = 4'h8,
      REG_PRESCALE   = 4'h9
   } mmio_reg_t;

   typedef enum logic [1:0] {
      OP_IDLE  = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2
   } reg_op_t;

   // Classify the current bus cycle; misses are always idle.
   function automatic reg_op_t decode_op(input logic strobe, input logic is_write,
                                         input logic hit);
      if (!strobe || !hit) return OP_IDLE;
      return is_write ? OP_WRITE : OP_READ;
   endfunction

endpackage

// File: rtl/mmio_debounce.sv
// One button channel: 2-flop synchronizer followed by a debouncer.
// The accepted level only follows the synced level after it has differed
// for DEBOUNCE_CYCLES consecutive cycles; a down-counter reloads on any
// agreement, so a single bounce restarts the wait. rise_o is a
// combinational pulse coincident with the clock edge that sets level_o.
module mmio_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rise_d;

   // Next debounced level and remaining-cycles counter
   always_comb begin
      level_d = level_q;
      cnt_d   = RELOAD;
      rise_d  = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == '0) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // Synchronizer, counter and level registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= RELOAD;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_d;

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped I/O responder sitting beside main memory on the CPU bus.
// Answers loads/stores in a 16-byte window at BASE_ADDR: LEDs, synced
// switches, debounced buttons with sticky press flags and, when the
// MMIO_TIMER_EN macro is defined, a prescaled 16-bit free-running timer
// with a high-byte snapshot for coherent two-byte reads.
// Without MMIO_TIMER_EN, offsets 0x6-0x9 read 0 and ignore writes.
module mmio_responder
   import mmio_responder_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR       = 16'hFF00,
   parameter int          DEBOUNCE_CYCLES = 16,
   parameter int          NUM_BUTTONS     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [15:0]            address,
   input  logic                   address_read_enable,
   input  logic                   enable,
   input  logic                   mode,
   input  logic [7:0]             data_in,
   output logic [7:0]             data_out,
   output logic                   data_out_en,
   input  logic [NUM_BUTTONS-1:0] buttons,
   input  logic [9:0]             switches,
   output logic [9:0]             led
);

   logic [15:0]            addr_q, addr_d;
   logic [9:0]             led_q, led_d;
   logic [9:0]             sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
   logic [NUM_BUTTONS-1:0] btn_edge_q, btn_edge_d;
   logic [7:0]             data_out_q, data_out_d;
   logic                   data_out_en_q, data_out_en_d;

   logic                   hit;
   mmio_reg_t              reg_sel;
   reg_op_t                op;
   logic [7:0]             rd_data;
   logic [NUM_BUTTONS-1:0] btn_pressed_raw, btn_level, btn_rise, btn_w1c;
   logic [7:0]             btn_state_ext, btn_edge_ext;

   // Decode uses the latched address, so an access refers to the address
   // captured on an earlier cycle.
   assign hit     = (addr_q[15:MMIO_WINDOW_BITS] == BASE_ADDR[15:MMIO_WINDOW_BITS]);
   assign reg_sel = mmio_reg_t'(addr_q[MMIO_WINDOW_BITS-1:0]);
   assign op      = decode_op(enable, mode, hit);

   // Buttons are active-low; the debouncers work on "pressed" levels.
   assign btn_pressed_raw = ~buttons;

   for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
      mmio_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .rst_n   (rst_n),
         .raw_i   (btn_pressed_raw[gi]),
         .level_o (btn_level[gi]),
         .rise_o  (btn_rise[gi])
      );
   end

   assign btn_w1c = ((op == OP_WRITE) && (reg_sel == REG_BTN_EDGE))
                    ? data_in[NUM_BUTTONS-1:0] : '0;

   // Zero-extend button vectors to the 8-bit data bus
   always_comb begin
      btn_state_ext                  = '0;
      btn_edge_ext                   = '0;
      btn_state_ext[NUM_BUTTONS-1:0] = btn_level;
      btn_edge_ext[NUM_BUTTONS-1:0]  = btn_edge_q;
   end

`ifdef MMIO_TIMER_EN
   logic [15:0] timer_q, timer_d;
   logic [7:0]  pre_cnt_q, pre_cnt_d;
   logic [7:0]  prescale_q, prescale_d;
   logic [7:0]  hi_snap_q, hi_snap_d;
   logic        run_q, run_d;
   logic        ctrl_wr, timer_clear;

   assign ctrl_wr     = (op == OP_WRITE) && (reg_sel == REG_TIMER_CTRL);
   assign timer_clear = ctrl_wr && data_in[TCTRL_CLEAR];

   // Timer next state: clear beats increment; prescaler wraps at PRESCALE
   always_comb begin
      timer_d    = timer_q;
      pre_cnt_d  = pre_cnt_q;
      run_d      = ctrl_wr ? data_in[TCTRL_RUN] : run_q;
      prescale_d = ((op == OP_WRITE) && (reg_sel == REG_PRESCALE)) ? data_in : prescale_q;
      hi_snap_d  = ((op == OP_READ) && (reg_sel == REG_TIMER_LO)) ? timer_q[15:8] : hi_snap_q;
      if (timer_clear) begin
         timer_d   = '0;
         pre_cnt_d = '0;
      end else if (run_q) begin
         if (pre_cnt_q == prescale_q) begin
            pre_cnt_d = '0;
            timer_d   = timer_q + 16'd1;
         end else begin
            pre_cnt_d = pre_cnt_q + 8'd1;
         end
      end
   end

   // Timer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q    <= '0;
         pre_cnt_q  <= '0;
         prescale_q <= '0;
         hi_snap_q  <= '0;
         run_q      <= 1'b0;
      end else begin
         timer_q    <= timer_d;
         pre_cnt_q  <= pre_cnt_d;
         prescale_q <= prescale_d;
         hi_snap_q  <= hi_snap_d;
         run_q      <= run_d;
      end
   end
`endif

   // Read data mux over the register map
   always_comb begin
      rd_data = 8'h00;
      case (reg_sel)
         REG_LED_LO:     rd_data = led_q[7:0];
         REG_LED_HI:     rd_data = {6'b0, led_q[9:8]};
         REG_SW_LO:      rd_data = sw_s2_q[7:0];
         REG_SW_HI:      rd_data = {6'b0, sw_s2_q[9:8]};
         REG_BTN_STATE:  rd_data = btn_state_ext;
         REG_BTN_EDGE:   rd_data = btn_edge_ext;
`ifdef MMIO_TIMER_EN
         REG_TIMER_LO:   rd_data = timer_q[7:0];
         REG_TIMER_HI:   rd_data = hi_snap_q;
         REG_TIMER_CTRL: rd_data = {7'b0, run_q};
         REG_PRESCALE:   rd_data = prescale_q;
`endif
         default:        rd_data = 8'h00;
      endcase
   end

   // Next state for address latch, LEDs, switch sync, edge flags and read port.
   // A press edge arriving with a W1C on the same bit keeps the flag set.
   always_comb begin
      addr_d = address_read_enable ? address : addr_q;
      led_d  = led_q;
      if ((op == OP_WRITE) && (reg_sel == REG_LED_LO)) led_d[7:0] = data_in;
      if ((op == OP_WRITE) && (reg_sel == REG_LED_HI)) led_d[9:8] = data_in[1:0];
      sw_s1_d       = switches;
      sw_s2_d       = sw_s1_q;
      btn_edge_d    = (btn_edge_q & ~btn_w1c) | btn_rise;
      data_out_en_d = (op == OP_READ);
      data_out_d    = (op == OP_READ) ? rd_data : data_out_q;
   end

   // Core registers; reset also kills any pending read response at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q        <= '0;
         led_q         <= '0;
         sw_s1_q       <= '0;
         sw_s2_q       <= '0;
         btn_edge_q    <= '0;
         data_out_q    <= '0;
         data_out_en_q <= 1'b0;
      end else begin
         addr_q        <= addr_d;
         led_q         <= led_d;
         sw_s1_q       <= sw_s1_d;
         sw_s2_q       <= sw_s2_d;
         btn_edge_q    <= btn_edge_d;
         data_out_q    <= data_out_d;
         data_out_en_q <= data_out_en_d;
      end
   end

   assign data_out    = data_out_q;
   assign data_out_en = data_out_en_q;
   assign led         = led_q;

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-mapped peripheral responder on the CPU data/address bus, alongside main memory.
- Answers CPU loads and stores that fall inside a 16-byte window at BASE_ADDR.
- Exposes LEDs, switches, debounced buttons with sticky press flags, and an optional free-running timer.
- Gives the CPU program-level I/O; the 8-bit datapath no longer reads LEDs from an internal register.

Parameters:
- BASE_ADDR, 16'hFF00, start of window; low 4 bits must be 0.
- DEBOUNCE_CYCLES, 16, clock cycles a synchronized button level must hold before it is accepted.
- NUM_BUTTONS, 4, number of button inputs (1..8).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- address  in  16  CPU address bus
- address_read_enable  in  1  latch address this cycle
- enable  in  1  bus access strobe
- mode  in  1  1 = write (CPU drives data), 0 = read
- data_in  in  8  CPU data bus (write data)
- data_out  out  8  read data toward data bus
- data_out_en  out  1  responder drives data bus this cycle
- buttons  in  NUM_BUTTONS  raw buttons, active-low, asynchronous
- switches  in  10  raw switches, quasi-static
- led  out  10  LED outputs

Behaviour:
- Reset values: led=0, data_out=0, data_out_en=0, addr latch=0, btn_state=0 (released), btn_edge=0, timer=0, timer_ctrl=0, prescale=0.
- Address latch: addr_q <= address whenever address_read_enable=1. Otherwise it holds.
- Hit decode: hit = (addr_q[15:4] == BASE_ADDR[15:4]). On a miss, the block never drives the bus and ignores writes.
- Write: enable && mode && hit updates the addressed register at the clock edge. No response cycle.
- Read: enable && !mode && hit registers the selected value into data_out. data_out_en is high for exactly the next cycle. Read latency is 1 cycle.
- Read response bus state: data_out_en returns to 0 the following cycle; data_out holds its last value. Back-to-back reads produce back-to-back responses.
- Register map (offset, access):
  - 0x0 LED_LO (RW): led[7:0].
  - 0x1 LED_HI (RW): led[9:8] in bits[1:0]; upper bits read 0.
  - 0x2 SW_LO (RO): synced switches[7:0].
  - 0x3 SW_HI (RO): switches[9:8] in bits[1:0].
  - 0x4 BTN_STATE (RO): debounced pressed levels, 1 = pressed.
  - 0x5 BTN_EDGE (R/W1C): sticky press flags.
  - 0x6 TIMER_LO (RO).
  - 0x7 TIMER_HI (RO): returns the snapshot.
  - 0x8 TIMER_CTRL (RW): bit0 = run, bit1 = clear (self-clearing, reads 0).
  - 0x9 PRESCALE (RW).
  - 0xA–0xF: read 0x00, writes ignored.
- Switch synchronization: switches pass through a 2-flop synchronizer.
- Button path:
  - Each raw button is inverted, passed through a 2-flop synchronizer, then debounced.
  - The debounced level changes only after the synced level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A 0->1 debounced transition sets btn_edge[i].
  - If a W1C write and a new edge hit the same bit in the same cycle, set wins.
- Timer:
  - While run=1, the prescale counter counts 0..PRESCALE. On wrap, the 16-bit timer increments.
  - PRESCALE=0 means increment every cycle.
  - The timer wraps 0xFFFF -> 0x0000 silently.
  - clear zeroes both the timer and the prescale counter, and takes priority over an increment in the same cycle.
  - Reading TIMER_LO copies timer[15:8] into hi_snap in the same cycle, giving a coherent 16-bit read.
- Reset mid-access: a pending read response is dropped and data_out_en goes low immediately (asynchronous).

Optional Feature:
- Macro: MMIO_TIMER_EN.
- Defined: timer, prescaler and snapshot are present as described.
- Undefined:
  - No timer logic is instantiated.
  - Offsets 0x6–0x9 read 0x00 and writes to them are ignored.
  - All other behaviour is unchanged.

Decomposition:
- Shared package: mmio_reg_t enum with the offsets above, plus MMIO_WINDOW_BITS=4 and reg_op_t reuse.
- Sub-module: mmio_debounce (synchronizer, counter, level out, rise pulse out), instantiated once per button via generate.

Test Plan:
- Reset, then read offset 0x0 at 0xFF00: data_out_en high for exactly 1 cycle after enable, data_out=0x00.
- Write 0xA5 to 0xFF00 and 0x03 to 0xFF01 -> led=10'h3A5; reads return 0xA5 and 0x03; an access to 0xFE00 leaves data_out_en at 0 and led unchanged.
- Button 0 pressed (raw 0) with a 3-cycle bounce, then stable, DEBOUNCE_CYCLES=16:
  - BTN_STATE bit0 = 1 exactly 16 cycles after the last bounce, plus 2 sync cycles.
  - BTN_EDGE = 0x01.
  - Writing 0x01 to 0xFF05 clears it.
  - A new edge in the same cycle as the W1C leaves the bit set.
- Timer (MMIO_TIMER_EN): PRESCALE=3, run=1 -> timer increments every 4 cycles. Preload near 0x00FF: a TIMER_LO read returning 0xFF followed by a TIMER_HI read returns 0x00 even if the timer has since rolled to 0x0100.
- Clear and increment in the same cycle -> timer=0. Timer at 0xFFFF with PRESCALE=0 -> 0x0000 next cycle.
- rst_n asserted the cycle after a read enable -> data_out_en stays 0, led=0, btn_edge=0.
